// File: rtl/md_rst_seq_pkg.sv
// rtl/md_rst_seq_pkg.sv - shared types and default timings for md_rst_seq
package md_rst_seq_pkg;

  typedef enum logic [1:0] {
    OP_PULSE = 2'd0,
    OP_COLD  = 2'd1,
    OP_EXIT  = 2'd2,
    OP_NOP   = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PULSE_HOLD = 3'd1,
    ST_COLD_OFF   = 3'd2,
    ST_COLD_INIT  = 3'd3,
    ST_AUTO_HOLD  = 3'd4,
    ST_EXITED     = 3'd5
  } state_e;

  localparam int DEB_MS_DEF      = 8;
  localparam int SDR_INIT_MS_DEF = 2;
  localparam int AUTO_MS_DEF     = 16;

endpackage

// File: rtl/md_rst_seq_srst_debounce.sv
// rtl/md_rst_seq_srst_debounce.sv - md_srst synchroniser and tick-based debounce
module srst_debounce
  import md_rst_seq_pkg::*;
#(
  parameter int DEB_MS = DEB_MS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_ms,
  input  logic md_srst,
  output logic press
);

  localparam int             CW       = $clog2(DEB_MS + 1);
  localparam logic [CW-1:0]  DEB_TOP  = CW'(DEB_MS);
  localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_MS - 1);

  logic          sync1;
  logic          level;
  logic [CW-1:0] cnt;

  // two-flop synchroniser for the asynchronous console soft-reset line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      level <= 1'b0;
    end else begin
      sync1 <= md_srst;
      level <= sync1;
    end
  end

  // count stable-high ticks; saturate at the threshold so a held button presses once
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!level) begin
      cnt <= '0;
    end else if (tick_ms && (cnt != DEB_TOP)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // the press fires on the very edge at which the count reaches the threshold
  assign press = level & tick_ms & (cnt == DEB_LAST);

endmodule

// File: rtl/md_rst_seq.sv
// rtl/md_rst_seq.sv - timed sequencer for md_rst, sdram_en and exit
module md_rst_seq
  import md_rst_seq_pkg::*;
#(
  parameter int DEB_MS      = DEB_MS_DEF,
  parameter int SDR_INIT_MS = SDR_INIT_MS_DEF,
  parameter bit AUTO_RST    = 1'b1,
  parameter int AUTO_MS     = AUTO_MS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_ms,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_ms,
  input  logic        md_srst,
  input  logic        srst_clr,
  output logic        md_rst,
  output logic        sdram_en,
  output logic        exit,
  output logic        busy,
  output logic        srst_evt,
  output logic [2:0]  state
);

  state_e      cur;
  logic [15:0] cnt;
  logic        timer_done;
  logic        press;

  srst_debounce #(
    .DEB_MS (DEB_MS)
  ) u_deb (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_ms (tick_ms),
    .md_srst (md_srst),
    .press   (press)
  );

  assign timer_done = (cnt == 16'd0);
  assign cmd_ready  = (cur == ST_IDLE);
  assign busy       = (cur != ST_IDLE);
  assign state      = cur;

  // sequencer: command launch, timed phases and registered pin drive
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur      <= ST_IDLE;
      cnt      <= 16'd0;
      md_rst   <= 1'b0;
      sdram_en <= 1'b0;
      exit     <= 1'b0;
    end else begin
      case (cur)
        ST_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op_e'(cmd_op))
              OP_PULSE: begin
                cur    <= ST_PULSE_HOLD;
                md_rst <= 1'b1;
                cnt    <= cmd_ms;
              end
              OP_COLD: begin
                cur      <= ST_COLD_OFF;
                md_rst   <= 1'b1;
                sdram_en <= 1'b0;
                cnt      <= cmd_ms;
              end
              OP_EXIT: begin
                cur    <= ST_EXITED;
                md_rst <= 1'b1;
                exit   <= 1'b1;
              end
              default: ;
            endcase
          end else if (press && AUTO_RST) begin
            // auto pulse only when no command claims this cycle
            cur    <= ST_AUTO_HOLD;
            md_rst <= 1'b1;
            cnt    <= 16'(AUTO_MS);
          end
        end
        ST_PULSE_HOLD, ST_AUTO_HOLD, ST_COLD_INIT: begin
          if (timer_done) begin
            md_rst <= 1'b0;
            cur    <= ST_IDLE;
          end else if (tick_ms) begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_COLD_OFF: begin
          if (timer_done) begin
            sdram_en <= 1'b1;
            cnt      <= 16'(SDR_INIT_MS);
            cur      <= ST_COLD_INIT;
          end else if (tick_ms) begin
            cnt <= cnt - 16'd1;
          end
        end
        ST_EXITED: ;
        default: cur <= ST_IDLE;
      endcase
    end
  end

  // sticky soft-reset event; a simultaneous press beats the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      srst_evt <= 1'b0;
    end else if (press) begin
      srst_evt <= 1'b1;
    end else if (srst_clr) begin
      srst_evt <= 1'b0;
    end
  end

endmodule
